// File: rtl/zet_exec_wb_if.sv
// Writeback handshake bundle: micro-op results in, regfile commit strobes out.
// The master drives results and observes commits; the slave is the pipeline.
interface zet_exec_wb_if #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int FLAGW = 9
);
  logic             in_valid;
  logic             in_ready;
  logic             in_we;
  logic [AW-1:0]    in_addr;
  logic [DW-1:0]    in_data;
  logic             in_byte;
  logic             in_high;
  logic             in_wrfl;
  logic [FLAGW-1:0] in_flags;

  logic             wb_we;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             wb_byte;
  logic             wb_high;
  logic             wb_wrfl;
  logic [FLAGW-1:0] wb_flags;
  logic             wr_ss;

  modport master (
    output in_valid, in_we, in_addr, in_data, in_byte, in_high, in_wrfl, in_flags,
    input  in_ready,
    input  wb_we, wb_addr, wb_data, wb_byte, wb_high, wb_wrfl, wb_flags, wr_ss
  );

  modport slave (
    input  in_valid, in_we, in_addr, in_data, in_byte, in_high, in_wrfl, in_flags,
    output in_ready,
    output wb_we, wb_addr, wb_data, wb_byte, wb_high, wb_wrfl, wb_flags, wr_ss
  );
endinterface

// File: rtl/zet_exec_wb.sv
// Execute-to-regfile writeback shift pipeline with operand forwarding; commits STAGES cycles after accept.
// block freezes every entry and drops in_ready; flush discards in-flight entries and also drops in_ready.
module zet_exec_wb #(
  parameter int          DW      = 16,
  parameter int          AW      = 4,
  parameter int          FLAGW   = 9,
  parameter int          STAGES  = 2,
  parameter int unsigned SS_ADDR = 10
) (
  input  logic               clk,
  input  logic               rst,
  zet_exec_wb_if.slave       bus,
  input  logic               block,
  input  logic               div_exc,
  input  logic               fetchst,
  input  logic               flush,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic               fwd_a_hit,
  output logic [DW-1:0]      fwd_a_data,
  output logic               fwd_b_hit,
  output logic [DW-1:0]      fwd_b_data,
  output logic               fwd_stall,
  output logic [2:0]         occupancy
);

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    data;
    logic             bw;
    logic             high;
    logic             wrfl;
    logic [FLAGW-1:0] flags;
  } ent_t;

  ent_t       ent_q [STAGES];
  ent_t       ent_in;
  ent_t       oldest;
  logic       accept;
  logic       commit_ok;
  logic       wb_we_i;
  logic [2:0] occ_q;

  assign bus.in_ready = !block && !flush;
  assign accept       = bus.in_valid && !block && !flush;
  assign oldest       = ent_q[STAGES-1];

  // Suppressed ops still occupy a slot so the sequencer sees them retire in order.
  always_comb begin
    ent_in = '0;
    if (accept) begin
      ent_in.valid = 1'b1;
      ent_in.we    = bus.in_we && !div_exc && !fetchst;
      ent_in.addr  = bus.in_addr;
      ent_in.data  = bus.in_data;
      ent_in.bw    = bus.in_byte;
      ent_in.high  = bus.in_high;
      ent_in.wrfl  = bus.in_wrfl && !div_exc;
      ent_in.flags = bus.in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) ent_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) ent_q[i].valid <= 1'b0;
    end else if (!block) begin
      ent_q[0] <= ent_in;
      for (int i = 1; i < STAGES; i++) ent_q[i] <= ent_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        occ_q <= 3'd0;
    else if (flush)  occ_q <= 3'd0;
    else if (!block) occ_q <= occ_q + 3'(accept) - 3'(oldest.valid);
  end

  assign occupancy = occ_q;

  assign commit_ok    = oldest.valid && !block && !flush;
  assign wb_we_i      = commit_ok && oldest.we;
  assign bus.wb_we    = wb_we_i;
  assign bus.wb_wrfl  = commit_ok && oldest.wrfl;
  assign bus.wb_addr  = oldest.valid ? oldest.addr  : '0;
  assign bus.wb_data  = oldest.valid ? oldest.data  : '0;
  assign bus.wb_byte  = oldest.valid && oldest.bw;
  assign bus.wb_high  = oldest.valid && oldest.high;
  assign bus.wb_flags = oldest.valid ? oldest.flags : '0;
  assign bus.wr_ss    = wb_we_i && (oldest.addr == AW'(SS_ADDR)) && !oldest.bw;

  // Walk oldest to youngest so the youngest matching entry is the last assignment.
  always_comb begin
    logic          a_found, a_byte, b_found, b_byte;
    logic [DW-1:0] a_dat, b_dat;
    a_found = 1'b0;
    a_byte  = 1'b0;
    a_dat   = '0;
    b_found = 1'b0;
    b_byte  = 1'b0;
    b_dat   = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].we && (ent_q[i].addr == rd_addr_a)) begin
        a_found = 1'b1;
        a_byte  = ent_q[i].bw;
        a_dat   = ent_q[i].data;
      end
      if (ent_q[i].valid && ent_q[i].we && (ent_q[i].addr == rd_addr_b)) begin
        b_found = 1'b1;
        b_byte  = ent_q[i].bw;
        b_dat   = ent_q[i].data;
      end
    end
    fwd_a_hit  = a_found && !a_byte;
    fwd_a_data = (a_found && !a_byte) ? a_dat : '0;
    fwd_b_hit  = b_found && !b_byte;
    fwd_b_data = (b_found && !b_byte) ? b_dat : '0;
    fwd_stall  = (a_found && a_byte) || (b_found && b_byte);
  end

endmodule

// File: tb/tb_zet_exec_wb.sv
// Directed bench for zet_exec_wb (STAGES=2, SS_ADDR=10): commits are checked by a scoreboard monitor,
// forwarding, occupancy and gating are checked directly against hand-computed values.
module tb_zet_exec_wb;
  logic       clk = 1'b0;
  logic       rst;
  logic       block, div_exc, fetchst, flush;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic       fwd_a_hit, fwd_b_hit, fwd_stall;
  logic [15:0] fwd_a_data, fwd_b_data;
  logic [2:0] occupancy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        bw;
    logic        high;
    logic        ss;
  } exp_t;
  exp_t sb[$];

  zet_exec_wb_if #(.DW(16), .AW(4), .FLAGW(9)) bus ();

  zet_exec_wb #(.DW(16), .AW(4), .FLAGW(9), .STAGES(2), .SS_ADDR(10)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .block(block), .div_exc(div_exc), .fetchst(fetchst), .flush(flush),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .fwd_stall(fwd_stall), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_we    = 1'b0;
    bus.in_addr  = 4'd0;
    bus.in_data  = 16'd0;
    bus.in_byte  = 1'b0;
    bus.in_high  = 1'b0;
    bus.in_wrfl  = 1'b0;
    bus.in_flags = 9'd0;
  endtask

  task automatic op(input logic we, input logic [3:0] a, input logic [15:0] d,
                    input logic bw, input logic wrfl, input logic [8:0] fl);
    bus.in_valid = 1'b1;
    bus.in_we    = we;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_byte  = bw;
    bus.in_high  = 1'b0;
    bus.in_wrfl  = wrfl;
    bus.in_flags = fl;
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d, input logic bw, input logic ss);
    exp_t e;
    e.addr = a; e.data = d; e.bw = bw; e.high = 1'b0; e.ss = ss;
    sb.push_back(e);
  endtask

  // Commit monitor: every regfile strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.wb_we) begin
      exp_t act;
      act = {bus.wb_addr, bus.wb_data, bus.wb_byte, bus.wb_high, bus.wr_ss};
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL commit_unexpected: got addr=%0d data=%h, expected no commit",
                 bus.wb_addr, bus.wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (act === e) n_pass++;
        else $display("FAIL commit: got addr=%0d data=%h byte=%b high=%b ss=%b, expected addr=%0d data=%h byte=%b high=%b ss=%b",
                      act.addr, act.data, act.bw, act.high, act.ss, e.addr, e.data, e.bw, e.high, e.ss);
      end
    end
  end

  initial begin
    rst = 1'b0; block = 1'b0; div_exc = 1'b0; fetchst = 1'b0; flush = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    idle();
    #2;
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_we",    32'(bus.wb_we), 0);
    chk("rst_wrfl",  32'(bus.wb_wrfl), 0);
    chk("rst_ss",    32'(bus.wr_ss), 0);
    chk("rst_occ",   32'(occupancy), 0);
    chk("rst_data",  32'(bus.wb_data), 0);
    chk("rst_stall", 32'(fwd_stall), 0);
    chk("rst_ahit",  32'(fwd_a_hit), 0);
    cyc(); cyc();
    rst = 1'b1;

    // Basic latency and forwarding of a single word write
    op(1, 3, 16'h1234, 0, 0, 0); push(3, 16'h1234, 0, 0); rd_addr_a = 3;
    at_neg(); chk("t1_ready", 32'(bus.in_ready), 1); chk("t1_occ0", 32'(occupancy), 0);
    chk("t1_ahit0", 32'(fwd_a_hit), 0);
    cyc(); idle();
    at_neg(); chk("t1_occ1", 32'(occupancy), 1); chk("t1_we0", 32'(bus.wb_we), 0);
    chk("t1_ahit", 32'(fwd_a_hit), 1); chk("t1_adat", 32'(fwd_a_data), 32'h1234);
    cyc();
    at_neg(); chk("t1_we", 32'(bus.wb_we), 1); chk("t1_addr", 32'(bus.wb_addr), 3);
    chk("t1_data", 32'(bus.wb_data), 32'h1234); chk("t1_occ1b", 32'(occupancy), 1);
    cyc();
    at_neg(); chk("t1_occ_end", 32'(occupancy), 0); chk("t1_we_end", 32'(bus.wb_we), 0);
    chk("t1_ahit_end", 32'(fwd_a_hit), 0);

    // Youngest match wins
    cyc(); op(1, 3, 16'h1111, 0, 0, 0); push(3, 16'h1111, 0, 0);
    cyc(); op(1, 3, 16'hBEEF, 0, 0, 0); push(3, 16'hBEEF, 0, 0);
    cyc(); idle(); rd_addr_a = 3; rd_addr_b = 3;
    at_neg(); chk("t2_ahit", 32'(fwd_a_hit), 1); chk("t2_adat", 32'(fwd_a_data), 32'hBEEF);
    chk("t2_bdat", 32'(fwd_b_data), 32'hBEEF); chk("t2_occ", 32'(occupancy), 2);
    cyc();
    at_neg(); chk("t2_adat_old", 32'(fwd_a_data), 32'hBEEF);
    cyc();
    at_neg(); chk("t2_ahit_end", 32'(fwd_a_hit), 0);

    // Byte hazard stalls instead of forwarding
    cyc(); op(1, 5, 16'h00AB, 1, 0, 0); push(5, 16'h00AB, 1, 0); rd_addr_b = 5;
    at_neg(); chk("t3_stall0", 32'(fwd_stall), 0);
    cyc(); idle();
    at_neg(); chk("t3_stall", 32'(fwd_stall), 1); chk("t3_bhit", 32'(fwd_b_hit), 0);
    cyc();
    at_neg(); chk("t3_stall_c", 32'(fwd_stall), 1); chk("t3_byte", 32'(bus.wb_byte), 1);
    cyc();
    at_neg(); chk("t3_stall_end", 32'(fwd_stall), 0);

    // block freezes the pipe, ignores input, forwarding stays live
    rd_addr_a = 1;
    cyc(); op(1, 1, 16'h0101, 0, 0, 0); push(1, 16'h0101, 0, 0);
    cyc(); op(1, 2, 16'h0202, 0, 0, 0); push(2, 16'h0202, 0, 0);
    cyc(); block = 1'b1; op(1, 9, 16'h9999, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4_we", 32'(bus.wb_we), 0); chk("t4_ready", 32'(bus.in_ready), 0);
      chk("t4_occ", 32'(occupancy), 2); chk("t4_fwd", 32'(fwd_a_data), 32'h0101);
      cyc();
    end
    block = 1'b0; idle();
    at_neg(); chk("t4_rel_data", 32'(bus.wb_data), 32'h0101);
    cyc();
    at_neg(); chk("t4_rel_data2", 32'(bus.wb_data), 32'h0202); chk("t4_occ1", 32'(occupancy), 1);
    cyc();
    at_neg(); chk("t4_occ0", 32'(occupancy), 0); chk("t4_we_end", 32'(bus.wb_we), 0);

    // div_exc suppresses the write, the same op without it pulses wr_ss
    cyc(); div_exc = 1'b1; op(1, 10, 16'h5555, 0, 0, 0);
    cyc(); div_exc = 1'b0; idle();
    at_neg(); chk("t5_occ", 32'(occupancy), 1);
    cyc();
    at_neg(); chk("t5_we", 32'(bus.wb_we), 0); chk("t5_ss", 32'(bus.wr_ss), 0);
    chk("t5_addr", 32'(bus.wb_addr), 10);
    cyc(); op(1, 10, 16'h5555, 0, 0, 0); push(10, 16'h5555, 0, 1);
    cyc(); idle();
    cyc();
    at_neg(); chk("t5_ss_pulse", 32'(bus.wr_ss), 1);
    cyc();
    at_neg(); chk("t5_ss_low", 32'(bus.wr_ss), 0);

    // fetchst kills the register write but not the flags write
    cyc(); fetchst = 1'b1; op(1, 4, 16'h4444, 0, 1, 9'h1AB);
    cyc(); fetchst = 1'b0; idle();
    cyc();
    at_neg(); chk("t5_fs_we", 32'(bus.wb_we), 0); chk("t5_fs_wrfl", 32'(bus.wb_wrfl), 1);
    chk("t5_fs_flags", 32'(bus.wb_flags), 32'h1AB);
    cyc();
    at_neg(); chk("t5_fs_wrfl_end", 32'(bus.wb_wrfl), 0);

    // flush beats block and accept
    cyc(); op(1, 6, 16'h6666, 0, 0, 0);
    cyc(); op(1, 7, 16'h7777, 0, 0, 0);
    cyc(); flush = 1'b1; block = 1'b1; op(1, 8, 16'h8888, 0, 0, 0);
    at_neg(); chk("t6_we", 32'(bus.wb_we), 0); chk("t6_ready", 32'(bus.in_ready), 0);
    chk("t6_occ2", 32'(occupancy), 2);
    cyc(); flush = 1'b0; block = 1'b0; idle();
    at_neg(); chk("t6_occ0", 32'(occupancy), 0); chk("t6_we0", 32'(bus.wb_we), 0);
    cyc();
    at_neg(); chk("t6_we1", 32'(bus.wb_we), 0);

    // Asynchronous reset mid-stream
    cyc(); op(1, 8, 16'h8888, 0, 0, 0);
    cyc(); op(1, 9, 16'h9999, 0, 0, 0);
    cyc(); idle(); rd_addr_a = 9;
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_we", 32'(bus.wb_we), 0); chk("t6_rst_ready", 32'(bus.in_ready), 1);
    chk("t6_rst_occ", 32'(occupancy), 0); chk("t6_rst_ahit", 32'(fwd_a_hit), 0);
    chk("t6_rst_data", 32'(bus.wb_data), 0);
    cyc(); rst = 1'b1;
    at_neg(); chk("t6_post_occ", 32'(occupancy), 0);
    cyc(); cyc();
    at_neg(); chk("t6_post_we", 32'(bus.wb_we), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
